// File: rtl/core_task_loader_pkg.sv
// Shared widths and FSM encoding for the per-core task loader.
package core_task_loader_pkg;

    localparam int DEF_INSN_DATA_W = 256;
    localparam int DEF_INSN_W      = 16;
    localparam int DEF_R0_W        = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_LAUNCH = 2'd2,
        ST_RUN    = 2'd3
    } state_e;

endpackage

// File: rtl/core_task_loader.sv
// Per-core task receiver: latches one block on start, streams it into the core's
// instruction memory one slice per cycle, launches the core and waits for done.
module core_task_loader
    import core_task_loader_pkg::*;
#(
    parameter int INSN_DATA_W = DEF_INSN_DATA_W,
    parameter int INSN_W      = DEF_INSN_W,
    parameter int R0_W        = DEF_R0_W,
    localparam int N_INSN     = INSN_DATA_W / INSN_W,
    localparam int ADDR_W     = $clog2(N_INSN)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [INSN_DATA_W-1:0] insn_data,
    input  logic                   init_r0_en,
    input  logic [R0_W-1:0]        init_r0,
    output logic                   ready,
    output logic                   imem_we,
    output logic [ADDR_W-1:0]      imem_addr,
    output logic [INSN_W-1:0]      imem_wdata,
    output logic                   r0_we,
    output logic [R0_W-1:0]        r0_wdata,
    output logic                   core_start,
    input  logic                   core_done,
    output logic                   proto_err
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_INSN - 1);

    state_e                 state_q, state_d;
    logic [ADDR_W-1:0]      cnt_q, cnt_d;
    logic [INSN_DATA_W-1:0] data_q, data_d;
    logic                   ready_q, ready_d;
    logic                   imem_we_q, imem_we_d;
    logic [ADDR_W-1:0]      imem_addr_q, imem_addr_d;
    logic [INSN_W-1:0]      imem_wdata_q, imem_wdata_d;
    logic                   r0_we_q, r0_we_d;
    logic [R0_W-1:0]        r0_wdata_q, r0_wdata_d;
    logic                   core_start_q, core_start_d;
    logic                   proto_err_q, proto_err_d;
    logic                   accept;

    // A start is only taken when idle; any other start is a protocol error.
    assign accept = start && (state_q == ST_IDLE);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            data_q       <= '0;
            ready_q      <= 1'b1;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            r0_we_q      <= 1'b0;
            r0_wdata_q   <= '0;
            core_start_q <= 1'b0;
            proto_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            data_q       <= data_d;
            ready_q      <= ready_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            r0_we_q      <= r0_we_d;
            r0_wdata_q   <= r0_wdata_d;
            core_start_q <= core_start_d;
            proto_err_q  <= proto_err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LOAD;
                    cnt_d   = '0;
                    data_d  = insn_data;
                end
            end
            ST_LOAD: begin
                if (cnt_q == LAST_ADDR) begin
                    state_d = ST_LAUNCH;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_LAUNCH: state_d = ST_RUN;
            ST_RUN: begin
                if (core_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are computed from the next state so every port comes straight off a flop.
    always_comb begin
        ready_d      = (state_d == ST_IDLE);
        imem_we_d    = (state_d == ST_LOAD);
        imem_addr_d  = '0;
        imem_wdata_d = '0;
        if (state_d == ST_LOAD) begin
            imem_addr_d  = cnt_d;
            imem_wdata_d = data_d[INSN_W*cnt_d +: INSN_W];
        end
        r0_we_d      = accept && init_r0_en;
        r0_wdata_d   = (accept && init_r0_en) ? init_r0 : r0_wdata_q;
        core_start_d = (state_d == ST_LAUNCH);
        proto_err_d  = proto_err_q || (start && (state_q != ST_IDLE));
    end

    assign ready      = ready_q;
    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign r0_we      = r0_we_q;
    assign r0_wdata   = r0_wdata_q;
    assign core_start = core_start_q;
    assign proto_err  = proto_err_q;

endmodule

// File: tb/tb_core_task_loader.sv
// Directed bench for core_task_loader: expected imem/R0/launch events are queued
// by the driver and checked by a negedge monitor against the cycle they appear in.
module tb_core_task_loader;

    localparam int DW = 256;
    localparam int IW = 16;
    localparam int RW = 8;
    localparam int NI = 16;
    localparam int AW = 4;

    logic          clk;
    logic          reset;
    logic          start;
    logic [DW-1:0] insn_data;
    logic          init_r0_en;
    logic [RW-1:0] init_r0;
    logic          ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [IW-1:0] imem_wdata;
    logic          r0_we;
    logic [RW-1:0] r0_wdata;
    logic          core_start;
    logic          core_done;
    logic          proto_err;

    core_task_loader dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .insn_data  (insn_data),
        .init_r0_en (init_r0_en),
        .init_r0    (init_r0),
        .ready      (ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .r0_we      (r0_we),
        .r0_wdata   (r0_wdata),
        .core_start (core_start),
        .core_done  (core_done),
        .proto_err  (proto_err)
    );

    // ---------------- clock / cycle count ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [35:0] exp_w_q[$];   // {cycle, addr, data}
    logic [23:0] exp_r0_q[$];  // {cycle, r0 data}
    logic [15:0] exp_cs_q[$];  // {cycle}

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc + 1);
        end
    endtask

    task automatic unexpected(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=1 required=0 (cycle %0d)", name, cyc + 1);
    endtask

    // The bench calls "cycle c+1" the interval right after the edge that made cyc == c.
    always @(negedge clk) begin
        logic [35:0] ew;
        logic [23:0] er;
        logic [15:0] ec;
        if (imem_we === 1'b1) begin
            if (exp_w_q.size() == 0) begin
                unexpected("unexpected_imem_we");
            end else begin
                ew = exp_w_q.pop_front();
                check("imem_cycle", 32'(16'(cyc + 1)), 32'(ew[35:20]));
                check("imem_addr", 32'(imem_addr), 32'(ew[19:16]));
                check("imem_wdata", 32'(imem_wdata), 32'(ew[15:0]));
            end
        end
        if (r0_we === 1'b1) begin
            if (exp_r0_q.size() == 0) begin
                unexpected("unexpected_r0_we");
            end else begin
                er = exp_r0_q.pop_front();
                check("r0_cycle", 32'(16'(cyc + 1)), 32'(er[23:8]));
                check("r0_wdata", 32'(r0_wdata), 32'(er[7:0]));
            end
        end
        if (core_start === 1'b1) begin
            if (exp_cs_q.size() == 0) begin
                unexpected("unexpected_core_start");
            end else begin
                ec = exp_cs_q.pop_front();
                check("core_start_cycle", 32'(16'(cyc + 1)), 32'(ec));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    function automatic logic [DW-1:0] pattern(input logic [15:0] base, input logic [15:0] step);
        logic [DW-1:0] d;
        d = '0;
        for (int k = 0; k < NI; k++) d[k*IW +: IW] = 16'(base + step * 16'(k));
        return d;
    endfunction

    // Issues a start while idle; n_exp is how many writes are expected to land.
    task automatic issue_start(input logic [DW-1:0] d, input logic en, input logic [RW-1:0] r0,
                               input int n_exp, output int t0);
        insn_data  = d;
        init_r0_en = en;
        init_r0    = r0;
        start      = 1'b1;
        tick();
        t0         = cyc;
        start      = 1'b0;
        insn_data  = {8{$urandom}};
        init_r0_en = 1'b0;
        init_r0    = 8'($urandom);
        for (int k = 0; k < n_exp; k++) exp_w_q.push_back({16'(t0 + 1 + k), 4'(k), d[k*IW +: IW]});
        if (en) exp_r0_q.push_back({16'(t0 + 1), r0});
        if (n_exp == NI) exp_cs_q.push_back(16'(t0 + 17));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int t0, t1, t2, t3;
        reset      = 1'b0;
        start      = 1'b0;
        insn_data  = '0;
        init_r0_en = 1'b0;
        init_r0    = '0;
        core_done  = 1'b0;
        repeat (3) tick();

        check("rst_ready", ready, 1);
        check("rst_imem_we", imem_we, 0);
        check("rst_imem_addr", 32'(imem_addr), 0);
        check("rst_imem_wdata", 32'(imem_wdata), 0);
        check("rst_r0_we", r0_we, 0);
        check("rst_r0_wdata", 32'(r0_wdata), 0);
        check("rst_core_start", core_start, 0);
        check("rst_proto_err", proto_err, 0);

        reset = 1'b1;
        repeat (2) tick();

        // Stray done while idle.
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        tick();
        check("idle_done_ready", ready, 1);

        // Basic load, slice k = k, no R0.
        issue_start(pattern(16'h0000, 16'h0001), 1'b0, 8'h00, NI, t0);
        check("a_ready_t1", ready, 0);
        wait_until(t0 + 16);
        check("a_ready_t17", ready, 0);
        check("a_proto_err", proto_err, 0);
        wait_until(t0 + 24);
        check("a_ready_t25", ready, 0);
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        check("a_ready_t26", ready, 1);

        // Back-to-back start with R0 init; start during LOAD and stray done during LOAD.
        issue_start(pattern(16'hA5A5, 16'h0101), 1'b1, 8'hAB, NI, t1);
        wait_until(t1 + 4);
        start      = 1'b1;
        insn_data  = pattern(16'hDEAD, 16'h0003);
        init_r0_en = 1'b1;
        init_r0    = 8'h55;
        tick();
        start      = 1'b0;
        init_r0_en = 1'b0;
        check("b_proto_err_t6", proto_err, 1);
        check("b_ready_t6", ready, 0);
        wait_until(t1 + 7);
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        wait_until(t1 + 19);
        check("b_run_waits", ready, 0);
        wait_until(t1 + 21);
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        check("b_ready_done", ready, 1);
        check("b_proto_sticky", proto_err, 1);

        // Reset in the middle of LOAD: only slices 0..7 land.
        issue_start(pattern(16'hC000, 16'h0011), 1'b1, 8'h5A, 8, t2);
        wait_until(t2 + 7);
        reset = 1'b0;
        tick();
        check("c_rst_ready", ready, 1);
        check("c_rst_imem_we", imem_we, 0);
        check("c_rst_imem_addr", 32'(imem_addr), 0);
        check("c_rst_proto_err", proto_err, 0);
        check("c_rst_core_start", core_start, 0);
        reset = 1'b1;
        tick();

        // Fresh load from address 0 with minimum turnaround.
        issue_start(pattern(16'h0F0F, 16'h1000), 1'b0, 8'h00, NI, t3);
        wait_until(t3 + 17);
        check("d_ready_t18", ready, 0);
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        check("d_ready_t19", ready, 1);

        repeat (5) tick();
        check("left_imem", exp_w_q.size(), 0);
        check("left_r0", exp_r0_q.size(), 0);
        check("left_core_start", exp_cs_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
